// File: rtl/progmem_pkg.sv
// Shared types and constants for the loadable program memory.
// Optional parity storage is enabled with the PROGMEM_PARITY_EN macro.
package progmem_pkg;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    RUN   = 2'd1,
    LOAD  = 2'd2
  } state_e;

  localparam logic [15:0] NOP_WORD_DEFAULT = 16'h0000;

  // Opcode field values (top nibble of an instruction word)
  localparam logic [3:0] OP_LOAD_IMM = 4'b0001;
  localparam logic [3:0] OP_JMP      = 4'b1000;
  localparam logic [3:0] OP_OUT      = 4'b1111;

endpackage

// File: rtl/program_memory_if.sv
// Fetch and loader bus of the program memory. The parity_err signal exists only
// when PROGMEM_PARITY_EN is defined.
interface program_memory_if #(
  parameter int INST_W = 16,
  parameter int ADDR_W = 4
) ();
  // Loader handshake: a word transfers on every rising edge where load_valid
  // and load_ready are both high; load_last is only looked at on such a transfer.
  logic              fetch_en;
  logic [ADDR_W-1:0] fetch_addr;
  logic [INST_W-1:0] fetch_inst;
  logic              fetch_valid;
  logic              busy;
  logic              load_start;
  logic              load_valid;
  logic [INST_W-1:0] load_data;
  logic              load_last;
  logic              load_ready;
  logic              load_done;
`ifdef PROGMEM_PARITY_EN
  logic              parity_err;
`endif

  modport master (
    output fetch_en, fetch_addr, load_start, load_valid, load_data, load_last,
    input  fetch_inst, fetch_valid, busy, load_ready, load_done
`ifdef PROGMEM_PARITY_EN
    , input parity_err
`endif
  );

  modport slave (
    input  fetch_en, fetch_addr, load_start, load_valid, load_data, load_last,
    output fetch_inst, fetch_valid, busy, load_ready, load_done
`ifdef PROGMEM_PARITY_EN
    , output parity_err
`endif
  );

endinterface

// File: rtl/progmem_ram.sv
// Simple dual-port word array: one write port, one registered read port.
// The array itself has no reset; the owner clears it explicitly.
module progmem_ram #(
  parameter int W      = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [W-1:0]      wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [W-1:0]      rdata
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] rdata_q;

  // Read data holds when re is low, which gives the fetch port its hold behaviour.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    if (re) rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/program_memory.sv
// Loadable instruction memory: self-clear after reset, registered fetch port,
// valid/ready program loader. PROGMEM_PARITY_EN adds a stored even-parity bit.
module program_memory
  import progmem_pkg::*;
#(
  parameter int                INST_W   = 16,
  parameter int                ADDR_W   = 4,
  parameter logic [INST_W-1:0] NOP_WORD = INST_W'(NOP_WORD_DEFAULT)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  program_memory_if.slave        bus,
  output state_e                 dbg_state
);
`ifdef PROGMEM_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif
  localparam int RAM_W = INST_W + PAR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic              fetch_valid_q, fetch_valid_d;
  logic              nop_q, nop_d;
  logic              load_done_q, load_done_d;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [INST_W-1:0] ram_wdata_inst;
  logic [RAM_W-1:0]  ram_wdata;
  logic              ram_re;
  logic [RAM_W-1:0]  ram_rdata;

  // Reads only happen in RUN and writes only in CLEAR/LOAD, so the ports never collide.
  assign ram_re = (state_q == RUN) && bus.fetch_en;

  always_comb begin
    state_d        = state_q;
    clr_ptr_d      = clr_ptr_q;
    wr_ptr_d       = wr_ptr_q;
    load_done_d    = 1'b0;
    ram_we         = 1'b0;
    ram_waddr      = clr_ptr_q;
    ram_wdata_inst = NOP_WORD;
    case (state_q)
      CLEAR: begin
        ram_we    = 1'b1;
        clr_ptr_d = clr_ptr_q + ADDR_W'(1);
        if (clr_ptr_q == LAST_ADDR) state_d = RUN;
      end
      RUN: begin
        if (bus.load_start) begin
          state_d  = LOAD;
          wr_ptr_d = '0;
        end
      end
      LOAD: begin
        if (bus.load_valid) begin
          ram_we         = 1'b1;
          ram_waddr      = wr_ptr_q;
          ram_wdata_inst = bus.load_data;
          wr_ptr_d       = wr_ptr_q + ADDR_W'(1);
          // The pointer never wraps: a write at the last address ends the load.
          if (bus.load_last || (wr_ptr_q == LAST_ADDR)) begin
            state_d     = RUN;
            load_done_d = 1'b1;
          end
        end
      end
      default: state_d = CLEAR;
    endcase
    fetch_valid_d = ram_re;
    // Output shows NOP_WORD while stalled, and keeps showing it until the next real fetch.
    nop_d = !ram_re && ((state_d != RUN) || nop_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= CLEAR;
      clr_ptr_q     <= '0;
      wr_ptr_q      <= '0;
      fetch_valid_q <= 1'b0;
      nop_q         <= 1'b1;
      load_done_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      clr_ptr_q     <= clr_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      fetch_valid_q <= fetch_valid_d;
      nop_q         <= nop_d;
      load_done_q   <= load_done_d;
    end
  end

`ifdef PROGMEM_PARITY_EN
  assign ram_wdata      = {^ram_wdata_inst, ram_wdata_inst};
  assign bus.parity_err = fetch_valid_q && ((^ram_rdata[INST_W-1:0]) != ram_rdata[INST_W]);
`else
  assign ram_wdata      = ram_wdata_inst;
`endif

  progmem_ram #(
    .W      (RAM_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (ram_re),
    .raddr (bus.fetch_addr),
    .rdata (ram_rdata)
  );

  assign bus.fetch_inst  = nop_q ? NOP_WORD : ram_rdata[INST_W-1:0];
  assign bus.fetch_valid = fetch_valid_q;
  assign bus.busy        = (state_q != RUN);
  assign bus.load_ready  = (state_q == LOAD);
  assign bus.load_done   = load_done_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_program_memory.sv
// Bench for program_memory: a cycle-level behavioural model checked every cycle,
// plus literal expectations for reset, load and stall scenarios.
module tb_program_memory;
  import progmem_pkg::*;

  localparam int INST_W = 16;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;

  // ---------------- clock / reset ----------------
  logic   clk   = 1'b0;
  logic   rst_n = 1'b1;
  state_e dbg_state;

  always #5 clk = ~clk;

  program_memory_if #(.INST_W(INST_W), .ADDR_W(ADDR_W)) bus ();

  program_memory #(
    .INST_W   (INST_W),
    .ADDR_W   (ADDR_W),
    .NOP_WORD (16'h0000)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard counters ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 = clearing, 1 = running, 2 = loading
  logic [INST_W-1:0] m_mem [DEPTH];
  int                m_mode = 0;
  int                m_old_mode = 0;
  int                m_cnt = 0;
  int                m_ptr = 0;
  logic              exp_valid = 1'b0;
  logic              exp_busy  = 1'b1;
  logic              exp_ready = 1'b0;
  logic              exp_done  = 1'b0;
  logic [INST_W-1:0] exp_inst  = '0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_mode    = 0;
      m_cnt     = 0;
      m_ptr     = 0;
      exp_valid = 1'b0;
      exp_inst  = '0;
      exp_done  = 1'b0;
    end else begin
      m_old_mode = m_mode;
      exp_done   = 1'b0;
      exp_valid  = (m_old_mode == 1) && bus.fetch_en;
      if (exp_valid) exp_inst = m_mem[bus.fetch_addr];
      case (m_old_mode)
        0: begin
          m_mem[m_cnt] = '0;
          m_cnt++;
          if (m_cnt == DEPTH) begin
            m_mode = 1;
            m_cnt  = 0;
          end
        end
        1: if (bus.load_start) begin
          m_mode = 2;
          m_ptr  = 0;
        end
        default: if (bus.load_valid) begin
          m_mem[m_ptr] = bus.load_data;
          m_ptr++;
          if (bus.load_last || m_ptr == DEPTH) begin
            m_mode   = 1;
            exp_done = 1'b1;
          end
        end
      endcase
      if (!exp_valid && m_mode != 1) exp_inst = '0;
    end
    exp_busy  = (m_mode != 1);
    exp_ready = (m_mode == 2);
  end

  // ---------------- compare process ----------------
  bit chk_en   = 1'b0;
  int done_cnt = 0;

  initial forever begin
    @(negedge clk);
    if (bus.load_done) done_cnt++;
    if (chk_en && rst_n) begin
      chk("cyc_fetch_valid", 32'(bus.fetch_valid), 32'(exp_valid));
      chk("cyc_fetch_inst",  32'(bus.fetch_inst),  32'(exp_inst));
      chk("cyc_busy",        32'(bus.busy),        32'(exp_busy));
      chk("cyc_load_ready",  32'(bus.load_ready),  32'(exp_ready));
      chk("cyc_load_done",   32'(bus.load_done),   32'(exp_done));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.fetch_en   = 1'b0;
    bus.fetch_addr = '0;
    bus.load_start = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_data  = '0;
    bus.load_last  = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_busy",        32'(bus.busy),        32'd1);
    chk("rst_fetch_valid", 32'(bus.fetch_valid), 32'd0);
    chk("rst_fetch_inst",  32'(bus.fetch_inst),  32'h0000);
    chk("rst_load_ready",  32'(bus.load_ready),  32'd0);
    chk("rst_load_done",   32'(bus.load_done),   32'd0);
    idle_inputs();
    repeat (2) step();
    rst_n = 1'b1;
  endtask

  task automatic wait_run(output int n);
    n = 0;
    while (bus.busy && n < 100) begin
      step();
      n++;
    end
  endtask

  task automatic fetch1(input logic [ADDR_W-1:0] a, output logic [INST_W-1:0] inst,
                        output logic v);
    bus.fetch_en   = 1'b1;
    bus.fetch_addr = a;
    step();
    bus.fetch_en   = 1'b0;
    inst = bus.fetch_inst;
    v    = bus.fetch_valid;
  endtask

  logic [INST_W-1:0] words [DEPTH];

  task automatic load_seq(input int n, input bit use_last);
    bus.load_start = 1'b1;
    step();
    bus.load_start = 1'b0;
    for (int i = 0; i < n; i++) begin
      bus.load_valid = 1'b1;
      bus.load_data  = words[i];
      bus.load_last  = use_last && (i == n - 1);
      step();
    end
    bus.load_valid = 1'b0;
    bus.load_last  = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  logic [INST_W-1:0] got;
  logic              gv;
  int                ncyc;
  int                done_before;
  logic [INST_W-1:0] words2 [DEPTH];

  initial begin
    idle_inputs();
    #2;
    do_reset();
    chk_en = 1'b1;

    // Clear takes exactly DEPTH cycles, then every word reads as NOP
    wait_run(ncyc);
    chk("clear_cycles", 32'(ncyc), 32'd16);
    for (int a = 0; a < DEPTH; a++) begin
      fetch1(ADDR_W'(a), got, gv);
      chk("clear_word", 32'(got), 32'h0000);
      chk("clear_valid", 32'(gv), 32'd1);
    end

    // 12-word load terminated by load_last
    words[0]  = 16'h1E06; words[1]  = 16'h2A11; words[2]  = 16'h3B22; words[3]  = 16'h4C33;
    words[4]  = 16'h5D44; words[5]  = 16'h6E55; words[6]  = 16'h7F66; words[7]  = 16'h1077;
    words[8]  = 16'h2188; words[9]  = 16'h3299; words[10] = 16'h4AAA; words[11] = 16'h8A00;
    done_before = done_cnt;
    load_seq(12, 1'b1);
    chk("l12_busy_after", 32'(bus.busy), 32'd0);
    step();
    step();
    chk("l12_done_pulses", 32'(done_cnt - done_before), 32'd1);
    fetch1(4'd0, got, gv);
    chk("l12_addr0", 32'(got), 32'h1E06);
    fetch1(4'd11, got, gv);
    chk("l12_addr11", 32'(got), 32'h8A00);
    fetch1(4'd12, got, gv);
    chk("l12_addr12", 32'(got), 32'h0000);

    // Full 16-word load without load_last; a 17th word is refused
    for (int i = 0; i < DEPTH; i++) begin
      words2[i] = INST_W'($urandom);
      words[i]  = words2[i];
    end
    done_before = done_cnt;
    load_seq(16, 1'b0);
    bus.load_valid = 1'b1;
    bus.load_data  = 16'hFFFF;
    chk("l16_ready_after", 32'(bus.load_ready), 32'd0);
    step();
    bus.load_valid = 1'b0;
    step();
    chk("l16_done_pulses", 32'(done_cnt - done_before), 32'd1);
    fetch1(4'd0, got, gv);
    chk("l16_addr0", 32'(got), 32'(words2[0]));
    fetch1(4'd15, got, gv);
    chk("l16_addr15", 32'(got), 32'(words2[15]));

    // Stalled loader (valid 1,0,0,1) with fetch requested during the load
    bus.load_start = 1'b1;
    step();
    bus.load_start = 1'b0;
    bus.load_valid = 1'b1; bus.load_data = 16'hA5A5;
    bus.fetch_en   = 1'b1; bus.fetch_addr = 4'd5;
    step();
    chk("stall_fetch_valid", 32'(bus.fetch_valid), 32'd0);
    chk("stall_fetch_inst",  32'(bus.fetch_inst),  32'h0000);
    bus.load_valid = 1'b0;
    step();
    chk("stall_busy", 32'(bus.busy), 32'd1);
    step();
    bus.load_valid = 1'b1; bus.load_data = 16'h5A5A;
    step();
    bus.load_data = 16'hC3C3; bus.load_last = 1'b1;
    step();
    bus.load_valid = 1'b0; bus.load_last = 1'b0; bus.fetch_en = 1'b0;
    fetch1(4'd0, got, gv);
    chk("stall_addr0", 32'(got), 32'hA5A5);
    fetch1(4'd1, got, gv);
    chk("stall_addr1", 32'(got), 32'h5A5A);
    fetch1(4'd2, got, gv);
    chk("stall_addr2", 32'(got), 32'hC3C3);
    fetch1(4'd3, got, gv);
    chk("stall_addr3_kept", 32'(got), 32'(words2[3]));

`ifdef PROGMEM_PARITY_EN
    // Flip the stored parity bit of address 3 only; data bits are untouched
    dut.u_ram.mem_q[3][INST_W] = ~dut.u_ram.mem_q[3][INST_W];
    fetch1(4'd3, got, gv);
    chk("par_err_addr3", 32'(bus.parity_err), 32'd1);
    step();
    chk("par_err_idle", 32'(bus.parity_err), 32'd0);
    fetch1(4'd4, got, gv);
    chk("par_err_addr4", 32'(bus.parity_err), 32'd0);
    dut.u_ram.mem_q[3][INST_W] = ~dut.u_ram.mem_q[3][INST_W];
`endif

    // Randomised traffic: fetches, loads, stray load_valid/load_last
    for (int c = 0; c < 600; c++) begin
      bus.fetch_en   = 1'($urandom_range(0, 1));
      bus.fetch_addr = ADDR_W'($urandom_range(0, DEPTH - 1));
      bus.load_start = ($urandom_range(0, 15) == 0);
      bus.load_valid = ($urandom_range(0, 2) != 0);
      bus.load_data  = INST_W'($urandom);
      bus.load_last  = ($urandom_range(0, 7) == 0);
      step();
    end
    idle_inputs();
    bus.load_valid = 1'b1;
    bus.load_last  = 1'b1;
    bus.load_data  = 16'h0F0F;
    step();
    idle_inputs();
    step();
    for (int a = 0; a < DEPTH; a++) begin
      fetch1(ADDR_W'(a), got, gv);
    end

    // Reset in the middle of a load discards it and re-runs the clear
    for (int i = 0; i < DEPTH; i++) words[i] = 16'h8000 | 16'(i);
    load_seq(5, 1'b0);
    do_reset();
    wait_run(ncyc);
    chk("rst_mid_clear_cycles", 32'(ncyc), 32'd16);
    for (int a = 0; a < DEPTH; a++) begin
      fetch1(ADDR_W'(a), got, gv);
      chk("rst_mid_word", 32'(got), 32'h0000);
    end
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
